// File: rtl/count_seq_checker.sv
// Sequence checker for a 3-bit up-counter: tracks lock, counts 7->0 wraps and sequence errors.
// Build option: define SEQCHK_HOLD_EN to treat a repeated value (HOLD) as neutral instead of illegal.
module count_seq_checker #(
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 4,
    parameter int LOCK_LEN = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [2:0]        q_in,
    input  logic              clr_err,
    output logic              locked,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              wrap_pulse,
    output logic [1:0]        state_dbg
);

    // en is a one-way sample strobe: q_in is taken on every rising edge where en=1.
    // There is no back-pressure.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_LEN);
    localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_t            state, state_n;
    logic [2:0]        prev, prev_n;
    logic [3:0]        lock_cnt, lock_n;
    logic              err_n;
    logic [ERR_W-1:0]  err_cnt_n;
    logic [WRAP_W-1:0] wrap_cnt_n;
    logic              wrap_pulse_n;

    logic [2:0] prev_inc;
    logic [3:0] lock_inc;
    logic       is_inc;
    logic       is_wrap;
    logic       is_restart;
    logic       is_hold;
    logic       is_advance;
    logic       is_illegal;
    logic       err_evt;

    assign prev_inc   = prev + 3'd1;
    assign lock_inc   = lock_cnt + 4'd1;
    assign is_inc     = (q_in == prev_inc);
    assign is_wrap    = is_inc && (prev == 3'd7);
    assign is_restart = (q_in == 3'd0) && (prev != 3'd7);
    assign is_hold    = (q_in == prev);
    // A step that moves the lock counter; a neutral HOLD is legal but does not advance.
    assign is_advance = is_inc || is_restart;

`ifdef SEQCHK_HOLD_EN
    assign is_illegal = !(is_advance || is_hold);
`else
    assign is_illegal = !is_advance;
`endif

    always_comb begin
        state_n      = state;
        prev_n       = prev;
        lock_n       = lock_cnt;
        err_n        = err;
        err_cnt_n    = err_cnt;
        wrap_cnt_n   = wrap_cnt;
        wrap_pulse_n = 1'b0;
        err_evt      = 1'b0;

        if (en) begin
            prev_n = q_in;
            case (state)
                IDLE: begin
                    lock_n  = 4'd0;
                    state_n = SYNC;
                end
                SYNC: begin
                    if (is_illegal) begin
                        err_evt = 1'b1;
                        lock_n  = 4'd0;
                    end else if (is_advance) begin
                        lock_n = lock_inc;
                        if (lock_inc >= LOCK_TGT) begin
                            state_n = TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (is_illegal) begin
                        err_evt = 1'b1;
                        lock_n  = 4'd0;
                        state_n = SYNC;
                    end else if (is_wrap) begin
                        wrap_cnt_n   = wrap_cnt + 1'b1;
                        wrap_pulse_n = 1'b1;
                    end
                end
                default: begin
                    lock_n  = 4'd0;
                    state_n = IDLE;
                end
            endcase
        end

        if (clr_err) begin
            err_n     = 1'b0;
            err_cnt_n = '0;
        end

        // An error in the same cycle as a clear lands on top of the cleared count.
        if (err_evt) begin
            err_n = 1'b1;
            if (clr_err) begin
                err_cnt_n = ERR_ONE;
            end else if (err_cnt != ERR_MAX) begin
                err_cnt_n = err_cnt + ERR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            prev       <= 3'd0;
            lock_cnt   <= 4'd0;
            err        <= 1'b0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            prev       <= prev_n;
            lock_cnt   <= lock_n;
            err        <= err_n;
            err_cnt    <= err_cnt_n;
            wrap_cnt   <= wrap_cnt_n;
            wrap_pulse <= wrap_pulse_n;
        end
    end

    assign locked    = (state == TRACK);
    assign state_dbg = state;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: expected output tuples are queued per sample and checked by a monitor.
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       clr;
    logic       en;
    logic [2:0] q_in;
    logic       clr_err;
    logic       locked;
    logic       err;
    logic [3:0] err_cnt;
    logic [7:0] wrap_cnt;
    logic       wrap_pulse;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int step   = 0;
    logic [14:0] exp_q[$];

    count_seq_checker #(.WRAP_W(8), .ERR_W(4), .LOCK_LEN(3)) dut (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .q_in      (q_in),
        .clr_err   (clr_err),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt),
        .wrap_cnt  (wrap_cnt),
        .wrap_pulse(wrap_pulse),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [14:0] outs();
        return {locked, err, err_cnt, wrap_cnt, wrap_pulse};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got locked=%b err=%b err_cnt=%0d wrap_cnt=%0d pulse=%b, want locked=%b err=%b err_cnt=%0d wrap_cnt=%0d pulse=%b",
                     name, act[14], act[13], act[12:9], act[8:1], act[0],
                     exp[14], exp[13], exp[12:9], exp[8:1], exp[0]);
        end
    endtask

    // driver
    task automatic samp(input logic [2:0] q, input logic ce, input logic l, input logic e,
                        input logic [3:0] ec, input logic [7:0] wc, input logic p);
        @(negedge clk);
        en      = 1'b1;
        q_in    = q;
        clr_err = ce;
        exp_q.push_back({l, e, ec, wc, p});
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        en      = 1'b0;
        clr_err = 1'b0;
        q_in    = 3'd6;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected samples never observed, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // scoreboard monitor
    initial begin
        logic [14:0] exp_v;
        forever begin
            @(posedge clk);
            if (en && clr) begin
                #1;
                step++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL step%0d: got a sample with no expectation queued, want queued entry", step);
                end else begin
                    exp_v = exp_q.pop_front();
                    check($sformatf("step%0d", step), outs(), exp_v);
                end
            end
        end
    end

    initial begin
        clr = 1'b1; en = 1'b0; clr_err = 1'b0; q_in = 3'd0;
        #1 clr = 1'b0;
        #11;
        check("reset", outs(), 15'd0);
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0", state_dbg);
        end
        @(negedge clk);
        clr = 1'b1;

        // lock on 5,6,7,0; the wrap seen while syncing is not counted
        samp(3'd5, 0, 0, 0, 4'd0, 8'd0, 0);
        samp(3'd6, 0, 0, 0, 4'd0, 8'd0, 0);
        samp(3'd7, 0, 0, 0, 4'd0, 8'd0, 0);
        samp(3'd0, 0, 1, 0, 4'd0, 8'd0, 0);

        // full lap in TRACK, one counted wrap
        for (int v = 1; v <= 7; v++) samp(3'(v), 0, 1, 0, 4'd0, 8'd0, 0);
        samp(3'd0, 0, 1, 0, 4'd0, 8'd1, 1);
        idle(1);
        check("pulse_after_idle", {8'd0, wrap_pulse, wrap_cnt[5:0]}, {8'd0, 1'b0, 6'd1});
        samp(3'd1, 0, 1, 0, 4'd0, 8'd1, 0);

        // skip 3->5 drops lock, then 6,7,0 relocks
        samp(3'd2, 0, 1, 0, 4'd0, 8'd1, 0);
        samp(3'd3, 0, 1, 0, 4'd0, 8'd1, 0);
        samp(3'd5, 0, 0, 1, 4'd1, 8'd1, 0);
        samp(3'd6, 0, 0, 1, 4'd1, 8'd1, 0);
        samp(3'd7, 0, 0, 1, 4'd1, 8'd1, 0);
        samp(3'd0, 0, 1, 1, 4'd1, 8'd1, 0);

        // clear errors, then 4 -> 0 restart keeps lock and does not count a wrap
        samp(3'd1, 1, 1, 0, 4'd0, 8'd1, 0);
        samp(3'd2, 0, 1, 0, 4'd0, 8'd1, 0);
        samp(3'd3, 0, 1, 0, 4'd0, 8'd1, 0);
        samp(3'd4, 0, 1, 0, 4'd0, 8'd1, 0);
        samp(3'd0, 0, 1, 0, 4'd0, 8'd1, 0);

        // 20 illegal steps saturate err_cnt at 15
        for (int i = 1; i <= 20; i++)
            samp((i % 2) ? 3'd3 : 3'd5, 0, 0, 1, (i < 15) ? 4'(i) : 4'd15, 8'd1, 0);
        // clear coincident with an error: error wins, count restarts at 1
        samp(3'd3, 1, 0, 1, 4'd1, 8'd1, 0);

        // relock, clear, second wrap, then a hold at 2
        samp(3'd4, 0, 0, 1, 4'd1, 8'd1, 0);
        samp(3'd5, 0, 0, 1, 4'd1, 8'd1, 0);
        samp(3'd6, 0, 1, 1, 4'd1, 8'd1, 0);
        samp(3'd7, 1, 1, 0, 4'd0, 8'd1, 0);
        samp(3'd0, 0, 1, 0, 4'd0, 8'd2, 1);
        samp(3'd1, 0, 1, 0, 4'd0, 8'd2, 0);
        samp(3'd2, 0, 1, 0, 4'd0, 8'd2, 0);
`ifdef SEQCHK_HOLD_EN
        samp(3'd2, 0, 1, 0, 4'd0, 8'd2, 0);
`else
        samp(3'd2, 0, 0, 1, 4'd1, 8'd2, 0);
`endif
        idle(1);
        drain();

        // asynchronous reset between edges
        #2 clr = 1'b0;
        #1;
        check("async_clr", outs(), 15'd0);
        @(negedge clk);
        clr = 1'b1;

        // relock from scratch; wrap count restarts at zero
        samp(3'd3, 0, 0, 0, 4'd0, 8'd0, 0);
        samp(3'd4, 0, 0, 0, 4'd0, 8'd0, 0);
        samp(3'd5, 0, 0, 0, 4'd0, 8'd0, 0);
        samp(3'd6, 0, 1, 0, 4'd0, 8'd0, 0);
        samp(3'd7, 0, 1, 0, 4'd0, 8'd0, 0);
        samp(3'd0, 0, 1, 0, 4'd0, 8'd1, 1);
        idle(1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
